sram_host_seq: RTL and testbench
================================

SRAM_HOST_SEQ -- requirements
Module: sram_host_seq

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, giving the SRAM word width (COLS).
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 2, giving the SRAM address width (ROWS).
REQ-003 The module SHALL have parameter TIMEOUT, default 15, giving the maximum read-wait cycles (>=1).
REQ-004 Ports SHALL be:
  clk  in  1  single clock; all logic on the rising edge
  rst  in  1  synchronous reset, active-high
  req_valid  in  1  host request present
  req_ready  out  1  sequencer can accept a request
  req_we  in  1  1=write, 0=read
  req_addr  in  ADDR_WIDTH  target word address
  req_wdata  in  DATA_WIDTH  write data
  rsp_valid  out  1  one-cycle response strobe
  rsp_err  out  1  read timed out (qualified by rsp_valid)
  rsp_rdata  out  DATA_WIDTH  read data (qualified by rsp_valid)
  serial_in  out  1  serial write bit to SRAM
  shift  out  1  SRAM shift-register enable
  w_en  out  1  SRAM write strobe
  r_en  out  1  SRAM read strobe
  addr  out  ADDR_WIDTH  SRAM address
  data_out  in  DATA_WIDTH  SRAM read data
  data_valid  in  1  SRAM read data valid
REQ-005 Clock and reset SHALL be exactly one clock (clk) and one synchronous active-high reset (rst).

Function
REQ-006 The FSM SHALL have states IDLE, SHIFT, WRITE, READ, WAIT, DONE.
REQ-007 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on a cycle with req_valid=1 and req_ready=1 (accept cycle T).
REQ-008 On accept, req_we, req_addr and req_wdata SHALL be captured; later changes on req_* SHALL have no effect until the next accept.
REQ-009 addr SHALL equal the captured address from T+1 until return to IDLE, and SHALL hold its last value in IDLE.
REQ-010 Write: IDLE->SHIFT; shift=1 for exactly DATA_WIDTH cycles (T+1..T+DATA_WIDTH); serial_in = captured wdata MSB first, bit DATA_WIDTH-1-i on SHIFT cycle i.
REQ-011 Write: SHIFT->WRITE; w_en=1 for exactly one cycle (T+DATA_WIDTH+1), shift=0.
REQ-012 Write: WRITE->DONE; rsp_valid=1, rsp_err=0 at T+DATA_WIDTH+2; rsp_rdata SHALL keep its previous value.
REQ-013 Read: IDLE->READ; r_en=1 for exactly one cycle (T+1); shift and w_en stay 0.
REQ-014 Read: READ->WAIT; data_valid SHALL be sampled only in WAIT; data_valid in any other state SHALL be ignored.
REQ-015 In WAIT, data_valid=1 at cycle C SHALL capture data_out into rsp_rdata and go to DONE, with rsp_valid=1, rsp_err=0 at C+1.
REQ-016 A WAIT cycle counter SHALL clear on entry to WAIT. If TIMEOUT WAIT cycles elapse with no data_valid, the FSM SHALL go to DONE with rsp_err=1 and rsp_rdata=0 (rsp_valid at T+2+TIMEOUT).
REQ-017 DONE SHALL last one cycle and then return to IDLE; rsp_valid SHALL be 1 only in DONE.
REQ-018 rsp_valid has no back-pressure; the host SHALL sample it in the strobe cycle.
REQ-019 shift, w_en and r_en SHALL be mutually exclusive and 0 in IDLE and DONE; serial_in SHALL be 0 outside SHIFT.
REQ-020 SRAM-side outputs and rsp_* SHALL be driven from registered state only, with no combinational path from req_* or data_* inputs.
REQ-021 Back-to-back requests: req_ready SHALL reassert the cycle after DONE; minimum issue interval is DATA_WIDTH+3 cycles for writes and 4 cycles for reads.

Reset
REQ-022 While rst=1 at a rising edge, the FSM SHALL go to IDLE, counters SHALL clear, and all outputs (req_ready, rsp_*, serial_in, shift, w_en, r_en, addr) SHALL be 0 in the following cycle.
REQ-023 req_ready SHALL be 0 in any cycle where rst=1, and 1 in the first cycle after rst deasserts.
REQ-024 Reset mid-operation SHALL abort the operation with no rsp_valid and no further shift, w_en or r_en pulse.

Verification (DATA_WIDTH=8, ADDR_WIDTH=2, TIMEOUT=15)
REQ-025 Write addr=1, wdata=0xA5 accepted at T -> shift=1 at T+1..T+8 with serial_in 1,0,1,0,0,1,0,1; w_en=1 at T+9 with addr=1; rsp_valid=1, rsp_err=0 at T+10; req_ready=1 at T+11.
REQ-026 Read addr=1, with data_valid=1 and data_out=0xA5 two cycles after r_en -> r_en=1 at T+1; rsp_valid=1, rsp_rdata=0xA5, rsp_err=0 at T+4.
REQ-027 Read with data_valid held 0 -> rsp_valid=1, rsp_err=1, rsp_rdata=0x00 at T+17; req_ready=1 at T+18.
REQ-028 rst=1 at T+4 of a write -> shift=0 from T+5; no w_en pulse, no rsp_valid; req_ready=1 the cycle after rst drops.
REQ-029 Stray data_valid=1 in IDLE or READ, and req_valid held during busy -> no response, no second accept; next accept only when req_ready=1.
REQ-030 Write 0x3C to addr 2 then read addr 2 back-to-back -> exact REQ-021 spacing; rsp_rdata=0x3C.

Source files
------------

// File: rtl/sram_host_seq.sv
// Host-side sequencer for a serially loaded SRAM: shifts write data in MSB first,
// pulses the write/read strobes and waits (bounded) for read data.
module sram_host_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  serial_in,
  output logic                  shift,
  output logic                  w_en,
  output logic                  r_en,
  output logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic                  data_valid
);

  localparam int MAX_CNT = (DATA_WIDTH > TIMEOUT) ? DATA_WIDTH : TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  typedef enum logic [2:0] {IDLE, SHIFT, WRITE, READ, WAIT, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   sreg_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic                    err_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Outputs decode state and registers only; req_*/data_* steer state_next alone.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_err    = 1'b0;
    serial_in  = 1'b0;
    shift      = 1'b0;
    w_en       = 1'b0;
    r_en       = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = !rst;
        if (req_valid && !rst) state_next = req_we ? SHIFT : READ;
      end
      SHIFT: begin
        shift     = 1'b1;
        serial_in = sreg_reg[DATA_WIDTH-1];
        if (cnt_reg == CNT_W'(DATA_WIDTH - 1)) state_next = WRITE;
      end
      WRITE: begin
        w_en       = 1'b1;
        state_next = DONE;
      end
      READ: begin
        r_en       = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (data_valid || cnt_reg == CNT_W'(TIMEOUT - 1)) state_next = DONE;
      end
      DONE: begin
        rsp_valid  = 1'b1;
        rsp_err    = err_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg  <= '0;
      sreg_reg  <= '0;
      rdata_reg <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            addr_reg <= req_addr;
            sreg_reg <= req_wdata;
            cnt_reg  <= '0;
          end
        end
        SHIFT: begin
          sreg_reg <= sreg_reg << 1;
          cnt_reg  <= cnt_reg + 1'b1;
        end
        WRITE: err_reg <= 1'b0;
        READ:  cnt_reg <= '0;
        WAIT: begin
          cnt_reg <= cnt_reg + 1'b1;
          // Data arriving on the last allowed cycle still wins over the timeout.
          if (data_valid) begin
            rdata_reg <= data_out;
            err_reg   <= 1'b0;
          end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            rdata_reg <= '0;
            err_reg   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign addr      = addr_reg;
  assign rsp_rdata = rdata_reg;

endmodule

// File: tb/tb_sram_host_seq.sv
// Bench for sram_host_seq: table of host transactions with a response scoreboard,
// plus hand-written sequences for reset, stray data_valid and held req_valid.
module tb_sram_host_seq;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          serial_in, shift, w_en, r_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_out;
  logic          data_valid;

  sram_host_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .serial_in(serial_in), .shift(shift), .w_en(w_en), .r_en(r_en),
    .addr(addr), .data_out(data_out), .data_valid(data_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int acc_cnt = 0;
  always @(posedge clk) if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
    int            t_acc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    int            dv_dly;   // data_valid in cycle T+1+dv_dly; -1 = never
    logic [DW-1:0] dout;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            exp_lat;  // accept cycle to rsp_valid cycle
    int            exp_gap;  // accept-to-accept spacing from previous entry; 0 = unchecked
  } vec_t;
  vec_t tbl[9];

  int n_vec = 0;
  int n_bad = 0;
  int last_acc = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response side of the scoreboard plus a per-cycle strobe exclusivity check.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("strobe_onehot", 32'($countones({shift, w_en, r_en}) <= 1), 32'd1);
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("rsp: cycle %0d rdata=0x%02h err=%0d latency=%0d", cyc, rsp_rdata, rsp_err, cyc - e.t_acc);
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", rsp_err, e.err);
          chk("rsp_latency", cyc - e.t_acc, e.lat);
        end
      end
    end
  end

  task automatic wait_ready();
    int guard = 0;
    while (!req_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_req(input vec_t v);
    int  t;
    bit  seen = 1'b0;
    wait_ready();
    t = cyc;
    if (v.exp_gap != 0) chk("issue_gap", t - last_acc, v.exp_gap);
    last_acc  = t;
    req_valid = 1'b1;
    req_we    = v.we;
    req_addr  = v.a;
    req_wdata = v.wd;
    sb.push_back('{v.exp_rdata, v.exp_err, v.exp_lat, t});
    $display("req: cycle %0d we=%0d addr=%0d wdata=0x%02h", t, v.we, v.a, v.wd);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = ~v.we;
    req_addr  = ~v.a;
    req_wdata = ~v.wd;
    if (v.we) begin
      for (int i = 0; i < DW; i++) begin
        @(negedge clk);
        chk("shift", shift, 1);
        chk("serial_in", serial_in, v.wd[DW-1-i]);
        chk("shift_addr", addr, v.a);
      end
      @(negedge clk);
      chk("w_en", w_en, 1);
      chk("w_shift", shift, 0);
      chk("w_addr", addr, v.a);
    end else begin
      @(negedge clk);
      chk("r_en", r_en, 1);
      chk("r_shift", shift, 0);
      chk("r_addr", addr, v.a);
    end
    for (int k = 0; k < 25; k++) begin
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      if (v.dv_dly >= 0 && cyc == t + 1 + v.dv_dly) begin
        data_valid = 1'b1;
        data_out   = v.dout;
      end else begin
        data_valid = 1'b0;
        data_out   = ~v.dout;
      end
      @(negedge clk);
    end
    data_valid = 1'b0;
    if (!seen) chk("rsp_missing", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, a0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    data_out = '0; data_valid = 1'b0;

    //           we  a   wd     dly dout   rdata  err lat gap
    tbl[0] = '{1'b1, 2'd1, 8'hA5, -1, 8'h00, 8'h00, 1'b0, 10, 0};
    tbl[1] = '{1'b0, 2'd1, 8'h00,  2, 8'hA5, 8'hA5, 1'b0,  4, 11};
    tbl[2] = '{1'b1, 2'd2, 8'h3C, -1, 8'h00, 8'hA5, 1'b0, 10, 5};
    tbl[3] = '{1'b0, 2'd2, 8'h00,  1, 8'h3C, 8'h3C, 1'b0,  3, 11};
    tbl[4] = '{1'b0, 2'd3, 8'h00, -1, 8'h00, 8'h00, 1'b1, 17, 4};
    tbl[5] = '{1'b1, 2'd0, 8'h81, -1, 8'h00, 8'h00, 1'b0, 10, 18};
    tbl[6] = '{1'b0, 2'd0, 8'h00, 15, 8'h5A, 8'h5A, 1'b0, 17, 11};
    tbl[7] = '{1'b0, 2'd3, 8'h00,  0, 8'hFF, 8'h00, 1'b1, 17, 18};
    tbl[8] = '{1'b0, 2'd1, 8'h00,  3, 8'hC3, 8'hC3, 1'b0,  5, 18};

    // Reset state
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    chk("rst_ready", req_ready, 0);
    chk("rst_outputs", {rsp_valid, rsp_err, serial_in, shift, w_en, r_en}, 0);
    chk("rst_addr", addr, 0);
    chk("rst_rdata", rsp_rdata, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1);

    foreach (tbl[i]) run_req(tbl[i]);

    // Stray data_valid in IDLE must not produce a response
    wait_ready();
    data_valid = 1'b1;
    data_out   = 8'hEE;
    repeat (3) begin
      @(negedge clk);
      chk("idle_stray_ready", req_ready, 1);
    end
    data_valid = 1'b0;

    // req_valid held through a read: exactly one accept until req_ready returns
    a0 = acc_cnt;
    t  = cyc;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 2'd2; req_wdata = 8'h11;
    sb.push_back('{8'h5C, 1'b0, 3, t});
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("busy_ready", req_ready, 0);
      data_valid = (k == 2);
      data_out   = 8'h5C;
    end
    data_valid = 1'b0;
    chk("busy_single_accept", acc_cnt - a0, 1);
    @(negedge clk);
    chk("busy_ready_back", req_ready, 1);
    req_addr = 2'd3;
    sb.push_back('{8'h00, 1'b1, 17, cyc});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 2'd0;
    @(negedge clk);
    chk("held_second_addr", addr, 3);
    chk("held_two_accepts", acc_cnt - a0, 2);
    repeat (17) @(negedge clk);

    // Reset in the middle of a write shift
    wait_ready();
    t = cyc;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 2'd3; req_wdata = 8'hFF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("pre_rst_shift", shift, 1);
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", req_ready, 0);
    @(negedge clk);
    chk("abort_shift", shift, 0);
    chk("abort_addr", addr, 0);
    chk("abort_ready_in_rst", req_ready, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_drop", req_ready, 1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("abort_quiet", {shift, w_en, r_en, rsp_valid}, 0);
    end
    chk("abort_elapsed", cyc - t, 21);

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
